// File: rtl/data_sram_responder.sv
// Single-port data SRAM model answering a simple ready/ren/wen request bus
// with optional fixed wait states, byte-masked writes and range checking.
module data_sram_responder #(
   parameter int unsigned             SRAM_ADDR_WD  = 32,
   parameter int unsigned             SRAM_DATA_WD  = 64,
   parameter int unsigned             SRAM_WMASK_WD = 8,
   parameter int unsigned             MEM_DEPTH_WD  = 10,
   parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR     = SRAM_ADDR_WD'(32'h8000_0000),
   parameter int unsigned             WAIT_CYCLES   = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
   input  logic                     i_data_sram_ren,
   input  logic                     i_data_sram_wen,
   input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wmask,
   input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
   output logic                     o_data_sram_ready,
   output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
   output logic                     o_data_sram_rvalid,
   output logic                     o_data_sram_wack,
   output logic                     o_data_sram_err
);

   localparam int unsigned CNT_WD    = 4;
   localparam int unsigned BYTE_WD   = 8;
   localparam int unsigned OFF_LSB   = 3;
   localparam int unsigned RANGE_LSB = MEM_DEPTH_WD + OFF_LSB;
   localparam int unsigned MEM_WORDS = 1 << MEM_DEPTH_WD;

   typedef struct packed {
      logic [SRAM_ADDR_WD-1:0]  addr;
      logic                     ren;
      logic                     wen;
      logic [SRAM_WMASK_WD-1:0] wmask;
      logic [SRAM_DATA_WD-1:0]  wdata;
   } req_t;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t                  state;
   logic [CNT_WD-1:0]       cnt;
   req_t                    req_q;
   logic                    ready_q;
   logic [SRAM_DATA_WD-1:0] rdata_q;
   logic                    rvalid_q;
   logic                    wack_q;
   logic                    err_q;

   logic [SRAM_DATA_WD-1:0] mem [MEM_WORDS];

   req_t                    live_req;
   req_t                    acc_req;
   logic                    accept;
   logic                    access;
   logic [SRAM_ADDR_WD-1:0] acc_off;
   logic                    in_range;
   logic [MEM_DEPTH_WD-1:0] acc_idx;

   // Zero wait states access the array straight off the bus; otherwise use the captured request.
   always_comb begin
      live_req = '{addr:  i_data_sram_addr,
                   ren:   i_data_sram_ren,
                   wen:   i_data_sram_wen,
                   wmask: i_data_sram_wmask,
                   wdata: i_data_sram_wdata};
      accept   = ready_q & (i_data_sram_ren | i_data_sram_wen);
      acc_req  = live_req;
      access   = accept;
      if (WAIT_CYCLES != 0) begin
         acc_req = req_q;
         access  = (state == ST_WAIT) && (cnt == CNT_WD'(1));
      end
      acc_off  = acc_req.addr - BASE_ADDR;
      in_range = ((acc_off >> RANGE_LSB) == '0);
      acc_idx  = acc_off[RANGE_LSB-1:OFF_LSB];
   end

   // Array contents are deliberately left out of the reset branch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         req_q    <= '0;
         ready_q  <= 1'b1;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wack_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         wack_q   <= 1'b0;
         err_q    <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept && (WAIT_CYCLES != 0)) begin
                  state   <= ST_WAIT;
                  cnt     <= CNT_WD'(WAIT_CYCLES);
                  req_q   <= live_req;
                  ready_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - CNT_WD'(1);
               if (cnt == CNT_WD'(1)) begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase

         // Read samples the old word before the masked write lands (read-before-write).
         if (access) begin
            rvalid_q <= acc_req.ren;
            wack_q   <= acc_req.wen;
            err_q    <= ~in_range;
            if (acc_req.ren) begin
               rdata_q <= in_range ? mem[acc_idx] : '0;
            end
            if (acc_req.wen && in_range) begin
               for (int unsigned b = 0; b < SRAM_WMASK_WD; b++) begin
                  if (acc_req.wmask[b]) begin
                     mem[acc_idx][b*BYTE_WD +: BYTE_WD] <= acc_req.wdata[b*BYTE_WD +: BYTE_WD];
                  end
               end
            end
         end
      end
   end

   assign o_data_sram_ready  = ready_q;
   assign o_data_sram_rdata  = rdata_q;
   assign o_data_sram_rvalid = rvalid_q;
   assign o_data_sram_wack   = wack_q;
   assign o_data_sram_err    = err_q;

endmodule
